dragster_spi_arbiter: RTL and testbench
=======================================

DRAGSTER_SPI_ARBITER -- requirements
Module: dragster_spi_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- TIMEOUT_CYCLES, 4096: maximum WAIT cycles before abort; legal range 1..65535.
- GUARD_CYCLES, 4: idle gap after each transaction; legal range 1..255.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- reqN_valid  in  1  requester N (N=0,1) has a transaction pending; payload stable while high.
- reqN_data  in  16  requester N command word.
- reqN_operation  in  1  requester N operation bit, passed to the SPI master.
- reqN_slave  in  2  requester N slave select index.
- reqN_ready  out  1  one-cycle pulse: request N accepted and payload latched.
- reqN_done  out  1  one-cycle pulse: transaction N finished.
- reqN_timeout  out  1  qualifies reqN_done; 1 = aborted by timeout.
- reqN_rdata  out  8  data captured at end of transaction N; holds until the next done for N.
- spi_enable  out  1  SPI master enable.
- spi_start_transaction  out  1  SPI master start pulse.
- spi_outgoing_data  out  16  latched command word.
- spi_operation  out  1  latched operation bit.
- spi_slave  out  2  latched slave index.
- spi_end_of_transaction  in  1  SPI master completion strobe.
- spi_incoming_data  in  8  SPI master received byte.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, START, WAIT and GUARD; all outputs SHALL be registered.
REQ-004 In IDLE with any reqN_valid=1, at the next edge the block SHALL:
- latch the winner's data, operation and slave;
- pulse winner reqN_ready for one cycle;
- record the winner in last_grant;
- go to START.
REQ-005 Arbitration SHALL be round-robin: with one valid, that requester wins; with both valid, the requester not equal to last_grant wins.
REQ-006 In START the block SHALL drive spi_enable=1 and spi_start_transaction=1 for exactly one cycle, clear the timer and go to WAIT.
REQ-007 In WAIT the block SHALL hold spi_enable=1 and spi_start_transaction=0 and increment a 16-bit timer each cycle.
REQ-008 On spi_end_of_transaction=1 in WAIT the block SHALL:
- capture spi_incoming_data into the granted reqN_rdata;
- pulse reqN_done with reqN_timeout=0;
- drop spi_enable;
- go to GUARD.
REQ-009 When the timer reaches TIMEOUT_CYCLES without end_of_transaction, the block SHALL pulse reqN_done with reqN_timeout=1, leave reqN_rdata unchanged, drop spi_enable and go to GUARD.
REQ-010 If end_of_transaction and timeout expiry occur in the same cycle, end_of_transaction SHALL take priority (timeout=0, data captured).
REQ-011 spi_end_of_transaction SHALL be ignored in IDLE, START and GUARD.
REQ-012 GUARD SHALL last exactly GUARD_CYCLES cycles with spi_enable=0, then return to IDLE; requests arriving during GUARD SHALL wait.
REQ-013 Latency: valid sampled in IDLE at edge k gives ready at k+1, start at k+2, and done one edge after the end_of_transaction cycle.
REQ-014 A requester that deasserts valid before ready SHALL NOT be served; a requester that keeps valid high after done SHALL be treated as a new request.
REQ-015 The latched payload SHALL NOT change between ready and done, regardless of reqN inputs.

Reset
REQ-016 With reset_n=0 at an edge, from any state including mid-transaction, the block SHALL set:
- state = IDLE;
- all spi_* outputs = 0, and ready/done/timeout = 0;
- reqN_rdata = 0, busy = 0, timer = 0;
- last_grant = 1, so requester 0 wins the first contention.
REQ-017 No done pulse SHALL be issued for a transaction aborted by reset.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- req0 only, data=16'h3A05, SPI model returns 8'hA5 after 20 cycles -> ready0 at k+1, start pulse at k+2, done0 with rdata0=8'hA5 and timeout0=0, busy low after GUARD_CYCLES.
- req0 and req1 valid together from reset -> req0 served first, then req1; repeat with both still valid -> req0 then req1 again (alternation).
- SPI model never ends, TIMEOUT_CYCLES=16 -> done with timeout=1 exactly 16 WAIT cycles after START, rdata unchanged, spi_enable=0.
- end_of_transaction on the timeout-expiry cycle -> timeout=0, data captured.
- reset_n pulsed low mid-WAIT -> all outputs 0 next edge, no done; next request re-arbitrates with req0 priority.
- Spurious end_of_transaction in IDLE/GUARD -> no done, no state change.

Source files
------------

// File: rtl/dragster_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dragster_spi_arbiter
//  Purpose  : Round-robin arbiter granting two requesters access to a single
//             SPI master, with a per-transaction timeout and an idle guard gap
//             between transactions.
//  Revision : 1.0 - initial release
// ============================================================================
module dragster_spi_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GUARD_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  input  logic        req0_operation,
  input  logic [1:0]  req0_slave,
  output logic        req0_ready,
  output logic        req0_done,
  output logic        req0_timeout,
  output logic [7:0]  req0_rdata,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  input  logic        req1_operation,
  input  logic [1:0]  req1_slave,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        req1_timeout,
  output logic [7:0]  req1_rdata,
  output logic        spi_enable,
  output logic        spi_start_transaction,
  output logic [15:0] spi_outgoing_data,
  output logic        spi_operation,
  output logic [1:0]  spi_slave,
  input  logic        spi_end_of_transaction,
  input  logic [7:0]  spi_incoming_data,
  output logic        busy
);

  localparam logic [15:0] c_timeout    = 16'(TIMEOUT_CYCLES);
  localparam logic [7:0]  c_guard_last = 8'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_last_grant;
  logic        r_grant;
  logic [15:0] r_timer;
  logic [7:0]  r_guard_cnt;

  logic        w_any_valid;
  logic        w_winner;
  logic [15:0] w_timer_next;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    w_any_valid  = req0_valid | req1_valid;
    w_timer_next = r_timer + 16'd1;
    if (req0_valid && req1_valid) begin
      w_winner = ~r_last_grant;
    end else begin
      w_winner = req1_valid;
    end
  end

  // Transaction sequencer; every output is registered here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state               <= ST_IDLE;
      r_last_grant          <= 1'b1;
      r_grant               <= 1'b0;
      r_timer               <= 16'd0;
      r_guard_cnt           <= 8'd0;
      req0_ready            <= 1'b0;
      req1_ready            <= 1'b0;
      req0_done             <= 1'b0;
      req1_done             <= 1'b0;
      req0_timeout          <= 1'b0;
      req1_timeout          <= 1'b0;
      req0_rdata            <= 8'd0;
      req1_rdata            <= 8'd0;
      spi_enable            <= 1'b0;
      spi_start_transaction <= 1'b0;
      spi_outgoing_data     <= 16'd0;
      spi_operation         <= 1'b0;
      spi_slave             <= 2'd0;
      busy                  <= 1'b0;
    end else begin
      // Handshake strobes are single-cycle pulses by default.
      req0_ready            <= 1'b0;
      req1_ready            <= 1'b0;
      req0_done             <= 1'b0;
      req1_done             <= 1'b0;
      req0_timeout          <= 1'b0;
      req1_timeout          <= 1'b0;
      spi_start_transaction <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_grant           <= w_winner;
            r_last_grant      <= w_winner;
            spi_outgoing_data <= w_winner ? req1_data      : req0_data;
            spi_operation     <= w_winner ? req1_operation : req0_operation;
            spi_slave         <= w_winner ? req1_slave     : req0_slave;
            req0_ready        <= ~w_winner;
            req1_ready        <= w_winner;
            busy              <= 1'b1;
            r_state           <= ST_START;
          end
        end

        ST_START: begin
          spi_enable            <= 1'b1;
          spi_start_transaction <= 1'b1;
          r_timer               <= 16'd0;
          r_state               <= ST_WAIT;
        end

        ST_WAIT: begin
          r_timer <= w_timer_next;
          // Completion wins over a timeout expiring on the same cycle.
          if (spi_end_of_transaction) begin
            if (r_grant) begin
              req1_rdata <= spi_incoming_data;
              req1_done  <= 1'b1;
            end else begin
              req0_rdata <= spi_incoming_data;
              req0_done  <= 1'b1;
            end
            spi_enable  <= 1'b0;
            r_guard_cnt <= 8'd0;
            r_state     <= ST_GUARD;
          end else if (w_timer_next == c_timeout) begin
            if (r_grant) begin
              req1_done    <= 1'b1;
              req1_timeout <= 1'b1;
            end else begin
              req0_done    <= 1'b1;
              req0_timeout <= 1'b1;
            end
            spi_enable  <= 1'b0;
            r_guard_cnt <= 8'd0;
            r_state     <= ST_GUARD;
          end
        end

        ST_GUARD: begin
          if (r_guard_cnt == c_guard_last) begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_guard_cnt <= r_guard_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dragster_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dragster_spi_arbiter
//  Purpose  : Directed, table-driven bench for dragster_spi_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dragster_spi_arbiter;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic        req0_operation, req1_operation;
  logic [1:0]  req0_slave, req1_slave;
  logic        spi_end_of_transaction;
  logic [7:0]  spi_incoming_data;

  // Outputs of the short-timeout instance (TIMEOUT_CYCLES=16)
  logic        s_ready0, s_ready1, s_done0, s_done1, s_to0, s_to1;
  logic [7:0]  s_rdata0, s_rdata1;
  logic        s_en, s_start, s_op, s_busy;
  logic [15:0] s_out;
  logic [1:0]  s_slave;

  // Outputs of the long-timeout instance (TIMEOUT_CYCLES=64)
  logic        l_ready0, l_ready1, l_done0, l_done1, l_to0, l_to1;
  logic [7:0]  l_rdata0, l_rdata1;
  logic        l_en, l_start, l_op, l_busy;
  logic [15:0] l_out;
  logic [1:0]  l_slave;

  dragster_spi_arbiter #(.TIMEOUT_CYCLES(16), .GUARD_CYCLES(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_operation(req0_operation),
    .req0_slave(req0_slave), .req0_ready(s_ready0), .req0_done(s_done0),
    .req0_timeout(s_to0), .req0_rdata(s_rdata0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_operation(req1_operation),
    .req1_slave(req1_slave), .req1_ready(s_ready1), .req1_done(s_done1),
    .req1_timeout(s_to1), .req1_rdata(s_rdata1),
    .spi_enable(s_en), .spi_start_transaction(s_start), .spi_outgoing_data(s_out),
    .spi_operation(s_op), .spi_slave(s_slave),
    .spi_end_of_transaction(spi_end_of_transaction), .spi_incoming_data(spi_incoming_data),
    .busy(s_busy)
  );

  dragster_spi_arbiter #(.TIMEOUT_CYCLES(64), .GUARD_CYCLES(4)) u_long (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_operation(req0_operation),
    .req0_slave(req0_slave), .req0_ready(l_ready0), .req0_done(l_done0),
    .req0_timeout(l_to0), .req0_rdata(l_rdata0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_operation(req1_operation),
    .req1_slave(req1_slave), .req1_ready(l_ready1), .req1_done(l_done1),
    .req1_timeout(l_to1), .req1_rdata(l_rdata1),
    .spi_enable(l_en), .spi_start_transaction(l_start), .spi_outgoing_data(l_out),
    .spi_operation(l_op), .spi_slave(l_slave),
    .spi_end_of_transaction(spi_end_of_transaction), .spi_incoming_data(spi_incoming_data),
    .busy(l_busy)
  );

  // Observed view: selects which instance the current vector checks.
  logic        sel_long;
  logic        o_ready0, o_ready1, o_done0, o_done1, o_to0, o_to1;
  logic [7:0]  o_rdata0, o_rdata1;
  logic        o_en, o_start, o_op, o_busy;
  logic [15:0] o_out;
  logic [1:0]  o_slave;

  assign o_ready0 = sel_long ? l_ready0 : s_ready0;
  assign o_ready1 = sel_long ? l_ready1 : s_ready1;
  assign o_done0  = sel_long ? l_done0  : s_done0;
  assign o_done1  = sel_long ? l_done1  : s_done1;
  assign o_to0    = sel_long ? l_to0    : s_to0;
  assign o_to1    = sel_long ? l_to1    : s_to1;
  assign o_rdata0 = sel_long ? l_rdata0 : s_rdata0;
  assign o_rdata1 = sel_long ? l_rdata1 : s_rdata1;
  assign o_en     = sel_long ? l_en     : s_en;
  assign o_start  = sel_long ? l_start  : s_start;
  assign o_op     = sel_long ? l_op     : s_op;
  assign o_busy   = sel_long ? l_busy   : s_busy;
  assign o_out    = sel_long ? l_out    : s_out;
  assign o_slave  = sel_long ? l_slave  : s_slave;

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;

  typedef struct {
    bit          do_reset;
    bit          use_long;
    bit          v0;
    bit          v1;
    logic [15:0] d0;
    logic [15:0] d1;
    bit          op0;
    bit          op1;
    logic [1:0]  s0;
    logic [1:0]  s1;
    int          eot_delay;   // WAIT edge on which end_of_transaction is high; 0 = never
    logic [7:0]  in_data;
    bit          exp_grant;
    bit          exp_timeout;
    logic [7:0]  exp_rdata;
    int          exp_lat;     // WAIT edges from START to done
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] out_bundle();
    return {20'd0, o_ready0, o_ready1, o_done0, o_done1, o_to0, o_to1, o_rdata0, o_rdata1,
            o_en, o_start, o_out, o_op, o_slave, o_busy};
  endfunction

  task automatic do_reset();
    reset_n                = 1'b0;
    req0_valid             = 1'b0;
    req1_valid             = 1'b0;
    spi_end_of_transaction = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // One full transaction: grant, start, wait/complete, guard gap.
  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] exp_data;
    logic        exp_op;
    logic [1:0]  exp_slave;
    bit          got;
    int          lat;
    if (v.do_reset) do_reset();
    sel_long               = v.use_long;
    req0_valid             = v.v0;
    req0_data              = v.d0;
    req0_operation         = v.op0;
    req0_slave             = v.s0;
    req1_valid             = v.v1;
    req1_data              = v.d1;
    req1_operation         = v.op1;
    req1_slave             = v.s1;
    spi_end_of_transaction = 1'b0;
    spi_incoming_data      = v.in_data;
    exp_data  = v.exp_grant ? v.d1  : v.d0;
    exp_op    = v.exp_grant ? v.op1 : v.op0;
    exp_slave = v.exp_grant ? v.s1  : v.s0;

    tick();  // grant edge
    chk($sformatf("v%0d ready0", idx), 64'(o_ready0), 64'(!v.exp_grant));
    chk($sformatf("v%0d ready1", idx), 64'(o_ready1), 64'(v.exp_grant));
    chk($sformatf("v%0d busy_grant", idx), 64'(o_busy), 64'd1);
    // Winner withdraws and scrambles its payload; the latched copy must hold.
    if (v.exp_grant) begin
      req1_valid = 1'b0; req1_data = ~v.d1; req1_operation = ~v.op1; req1_slave = ~v.s1;
    end else begin
      req0_valid = 1'b0; req0_data = ~v.d0; req0_operation = ~v.op0; req0_slave = ~v.s0;
    end

    tick();  // START edge
    chk($sformatf("v%0d start", idx), 64'({o_start, o_en}), 64'b11);
    chk($sformatf("v%0d payload", idx), 64'({o_out, o_op, o_slave}), 64'({exp_data, exp_op, exp_slave}));

    got = 1'b0;
    lat = 0;
    for (int j = 1; j <= 80; j++) begin
      spi_end_of_transaction = (j == v.eot_delay);
      tick();
      if (o_done0 || o_done1) begin
        got = 1'b1;
        lat = j;
        break;
      end
      if (j == 1) chk($sformatf("v%0d wait_drive", idx), 64'({o_start, o_en}), 64'b01);
    end
    spi_end_of_transaction = 1'b0;

    chk($sformatf("v%0d done_seen", idx), 64'(got), 64'd1);
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("v%0d done_who", idx), 64'({o_done0, o_done1}), 64'({!v.exp_grant, v.exp_grant}));
    chk($sformatf("v%0d timeout", idx), 64'(v.exp_grant ? o_to1 : o_to0), 64'(v.exp_timeout));
    chk($sformatf("v%0d rdata", idx), 64'(v.exp_grant ? o_rdata1 : o_rdata0), 64'(v.exp_rdata));
    chk($sformatf("v%0d en_off", idx), 64'(o_en), 64'd0);
    chk($sformatf("v%0d payload_hold", idx), 64'({o_out, o_op, o_slave}), 64'({exp_data, exp_op, exp_slave}));

    // Guard gap with a spurious completion strobe that must be ignored.
    spi_end_of_transaction = 1'b1;
    for (int g = 1; g <= 4; g++) begin
      tick();
      chk($sformatf("v%0d guard%0d strobes", idx, g),
          64'({o_done0, o_done1, o_ready0, o_ready1, o_en}), 64'd0);
      chk($sformatf("v%0d guard%0d busy", idx, g), 64'(o_busy), 64'(g < 4));
    end
    spi_end_of_transaction = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sel_long = 1'b0;
    reset_n  = 1'b0;
    req0_valid = 1'b0; req0_data = 16'h0; req0_operation = 1'b0; req0_slave = 2'd0;
    req1_valid = 1'b0; req1_data = 16'h0; req1_operation = 1'b0; req1_slave = 2'd0;
    spi_end_of_transaction = 1'b0;
    spi_incoming_data      = 8'h00;

    //          rst long v0 v1 d0        d1        op0 op1 s0    s1    eot in     gnt to  rdata  lat
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h3A05, 16'h0000, 1'b1, 1'b0, 2'd2, 2'd0, 20, 8'hA5, 1'b0, 1'b0, 8'hA5, 20};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1, 2'd1, 2'd3,  5, 8'h11, 1'b0, 1'b0, 8'h11,  5};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h2BCD, 1'b0, 1'b1, 2'd0, 2'd3,  7, 8'h22, 1'b1, 1'b0, 8'h22,  7};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h4321, 16'h8765, 1'b1, 1'b0, 2'd3, 2'd1,  3, 8'h33, 1'b0, 1'b0, 8'h33,  3};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h8765, 1'b0, 1'b0, 2'd0, 2'd1,  4, 8'h44, 1'b1, 1'b0, 8'h44,  4};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0F0F, 16'h0000, 1'b1, 1'b0, 2'd2, 2'd0,  0, 8'hFF, 1'b0, 1'b1, 8'h33, 16};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hF00D, 1'b0, 1'b1, 2'd0, 2'd2, 16, 8'h5C, 1'b1, 1'b0, 8'h5C, 16};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 2'd1, 2'd0,  1, 8'h77, 1'b0, 1'b0, 8'h77,  1};

    // Reset state of both instances
    tick();
    tick();
    chk("reset_outputs", out_bundle(), 64'd0);
    sel_long = 1'b1;
    chk("reset_outputs_long", out_bundle(), 64'd0);
    sel_long = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset mid-WAIT: last grant was requester 0, so without reset requester 1 would win next.
    sel_long   = 1'b0;
    req0_valid = 1'b1; req0_data = 16'h1234; req0_operation = 1'b1; req0_slave = 2'd3;
    tick();
    chk("midrst ready0", 64'(o_ready0), 64'd1);
    req0_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("midrst in_wait", 64'({o_en, o_busy}), 64'b11);
    reset_n = 1'b0;
    tick();
    chk("midrst outputs", out_bundle(), 64'd0);
    reset_n = 1'b1;

    // Spurious completion in IDLE must do nothing.
    spi_end_of_transaction = 1'b1;
    spi_incoming_data      = 8'hEE;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("idle_eot%0d", k), out_bundle(), 64'd0);
    end
    spi_end_of_transaction = 1'b0;

    // Contention after reset re-arbitrates with requester 0 first.
    req0_valid = 1'b1; req0_data = 16'hAAAA;
    req1_valid = 1'b1; req1_data = 16'h5555;
    tick();
    chk("post_rst ready", 64'({o_ready0, o_ready1}), 64'b10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk("post_rst payload", 64'(o_out), 64'hAAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
